fc_credit_tracker: RTL

FC_CREDIT_TRACKER -- requirements
Module: fc_credit_tracker

---
 rtl/fc_credit_tracker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fc_credit_tracker.sv
// fc_credit_tracker: flow-control credit limits and consumed counters for P/NP/Cpl classes.
// Class index 0=P, 1=NP, 2=Cpl; infinite_mask holds hdr at bit 2c and data at bit 2c+1.
module fc_credit_tracker #(
  parameter int HDR_WIDTH  = 8,
  parameter int DCRD_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  link_up,
  input  logic                  dllp_valid,
  input  logic [1:0]            dllp_type,
  input  logic [1:0]            dllp_class,
  input  logic [HDR_WIDTH-1:0]  dllp_hdr_fc,
  input  logic [DCRD_WIDTH-1:0] dllp_data_fc,
  input  logic                  tlp_sent,
  input  logic [1:0]            tlp_class,
  input  logic [DCRD_WIDTH-1:0] tlp_data_credits,
  output logic [HDR_WIDTH-1:0]  PH_credit_limit,
  output logic [HDR_WIDTH-1:0]  NPH_credit_limit,
  output logic [HDR_WIDTH-1:0]  CH_credit_limit,
  output logic [DCRD_WIDTH-1:0] PD_credit_limit,
  output logic [DCRD_WIDTH-1:0] NPD_credit_limit,
  output logic [DCRD_WIDTH-1:0] CD_credit_limit,
  output logic [HDR_WIDTH-1:0]  PH_consumed,
  output logic [HDR_WIDTH-1:0]  NPH_consumed,
  output logic [HDR_WIDTH-1:0]  CH_consumed,
  output logic [DCRD_WIDTH-1:0] PD_consumed,
  output logic [DCRD_WIDTH-1:0] NPD_consumed,
  output logic [DCRD_WIDTH-1:0] CD_consumed,
  output logic [5:0]            infinite_mask,
  output logic [1:0]            fc_state,
  output logic                  fc_init_done
);
  typedef enum logic [1:0] {IDLE = 2'b00, INIT1 = 2'b01, INIT2 = 2'b10, ACTIVE = 2'b11} state_e;
  state_e                       state_q, state_d;
  logic [2:0]                   seen_q, seen_d;
  logic [2:0][HDR_WIDTH-1:0]    hlim_q, hlim_d, hcon_q, hcon_d;
  logic [2:0][DCRD_WIDTH-1:0]   dlim_q, dlim_d, dcon_q, dcon_d;
  logic [5:0]                   inf_q, inf_d;
  logic                         done_q, done_d;
  logic                         dv, tv;
  logic [2:0]                   hi, di;
  assign dv = dllp_valid && dllp_type != 2'b11 && dllp_class != 2'b11;
  assign tv = tlp_sent && tlp_class != 2'b11 && state_q == ACTIVE;
  assign hi = {dllp_class, 1'b0};
  assign di = {dllp_class, 1'b1};
  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    hlim_d  = hlim_q;
    dlim_d  = dlim_q;
    hcon_d  = hcon_q;
    dcon_d  = dcon_q;
    inf_d   = inf_q;
    if (!link_up) begin
      state_d = IDLE;
      seen_d  = '0;
      hlim_d  = '0;
      dlim_d  = '0;
      hcon_d  = '0;
      dcon_d  = '0;
      inf_d   = '0;
    end else begin
      if (state_q == IDLE) state_d = INIT1;
      // A zero field in InitFC1 advertises infinite credit; a later repeat may clear it again
      if (state_q == INIT1 && dv && dllp_type == 2'b00) begin
        hlim_d[dllp_class] = dllp_hdr_fc;
        dlim_d[dllp_class] = dllp_data_fc;
        inf_d[hi]          = dllp_hdr_fc == '0;
        inf_d[di]          = dllp_data_fc == '0;
        seen_d[dllp_class] = 1'b1;
        if (&seen_d) state_d = INIT2;
      end
      if (state_q == INIT2 && dv && dllp_type != 2'b00) state_d = ACTIVE;
      if (state_q == ACTIVE && dv && dllp_type == 2'b10) begin
        if (!inf_q[hi]) hlim_d[dllp_class] = dllp_hdr_fc;
        if (!inf_q[di]) dlim_d[dllp_class] = dllp_data_fc;
      end
      if (tv) begin
        hcon_d[tlp_class] = hcon_q[tlp_class] + HDR_WIDTH'(1);
        dcon_d[tlp_class] = dcon_q[tlp_class] + tlp_data_credits;
      end
    end
    done_d = state_d == ACTIVE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seen_q  <= '0;
      hlim_q  <= '0;
      dlim_q  <= '0;
      hcon_q  <= '0;
      dcon_q  <= '0;
      inf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      hlim_q  <= hlim_d;
      dlim_q  <= dlim_d;
      hcon_q  <= hcon_d;
      dcon_q  <= dcon_d;
      inf_q   <= inf_d;
      done_q  <= done_d;
    end
  end
  assign PH_credit_limit  = hlim_q[0];
  assign NPH_credit_limit = hlim_q[1];
  assign CH_credit_limit  = hlim_q[2];
  assign PD_credit_limit  = dlim_q[0];
  assign NPD_credit_limit = dlim_q[1];
  assign CD_credit_limit  = dlim_q[2];
  assign PH_consumed      = hcon_q[0];
  assign NPH_consumed     = hcon_q[1];
  assign CH_consumed      = hcon_q[2];
  assign PD_consumed      = dcon_q[0];
  assign NPD_consumed     = dcon_q[1];
  assign CD_consumed      = dcon_q[2];
  assign infinite_mask    = inf_q;
  assign fc_state         = state_q;
  assign fc_init_done     = done_q;
endmodule
